// File: rtl/splitter4_fixed_if.sv
// rtl/splitter4_fixed_if.sv - sample/gain/output bundle for the four-way splitter
//
// Signals:
//   in           signed source sample, captured once per frame
//   gain1..gain4 unsigned Q0.GAINBITS target gain per channel
//   out1..out4   signed scaled channel samples
//   valid        one-cycle pulse when out1..out4 update
//   busy         high while a frame is being computed
// Modports: master drives in/gains and observes outputs; slave is the splitter.

interface splitter4_fixed_if #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
);
    logic signed [BITSIZE-1:0]  in;
    logic        [GAINBITS-1:0] gain1;
    logic        [GAINBITS-1:0] gain2;
    logic        [GAINBITS-1:0] gain3;
    logic        [GAINBITS-1:0] gain4;
    logic signed [BITSIZE-1:0]  out1;
    logic signed [BITSIZE-1:0]  out2;
    logic signed [BITSIZE-1:0]  out3;
    logic signed [BITSIZE-1:0]  out4;
    logic                       valid;
    logic                       busy;

    modport master (
        output in, gain1, gain2, gain3, gain4,
        input  out1, out2, out3, out4, valid, busy
    );

    modport slave (
        input  in, gain1, gain2, gain3, gain4,
        output out1, out2, out3, out4, valid, busy
    );
endinterface

// File: rtl/splitter4_fixed.sv
// rtl/splitter4_fixed.sv - one signed sample fanned out to four gain-scaled channels
//
// Ports:
//   bclk   bit clock (64 x lrclk), the only clock
//   reset  synchronous active-low reset
//   lrclk  frame clock, sampled as data; a rising edge starts a frame
//   bus    splitter4_fixed_if.slave: in, gain1..4, out1..4, valid, busy
// Optional feature: define SPLITTER_RAMP_EN to slew each channel's effective
// gain toward its target by at most RAMP_STEP per frame.
//
// One shared multiplier computes one channel per bclk. Timing from the cycle E
// in which the lrclk rising edge is seen: CALC in E+1..E+4, UPDATE in E+5,
// registered outputs and valid present in E+6.

module splitter4_fixed #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
`ifdef SPLITTER_RAMP_EN
    ,
    parameter int RAMP_STEP = 4
`endif
) (
    input  logic            bclk,
    input  logic            reset,
    input  logic            lrclk,
    splitter4_fixed_if.slave bus
);

    localparam int PW = BITSIZE + GAINBITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        UPDATE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                       lrclk_d;
    logic                       frame_start;
    logic signed [BITSIZE-1:0]  sample_r;
    logic        [GAINBITS-1:0] gain_in  [4];
    logic        [GAINBITS-1:0] eff_gain [4];
    logic        [GAINBITS-1:0] eff_next [4];
    logic signed [BITSIZE-1:0]  stage    [4];
    logic signed [BITSIZE-1:0]  out_r    [4];
    logic        [1:0]          ch;
    logic                       valid_r;

    logic                       latch_en;
    logic                       calc_en;
    logic                       update_en;
    logic                       busy_c;

    logic        [GAINBITS-1:0] eff_sel;
    logic signed [PW-1:0]       mul_a;
    logic signed [PW-1:0]       mul_b;
    logic signed [PW-1:0]       prod;
    logic signed [BITSIZE-1:0]  stage_d;

    assign gain_in[0] = bus.gain1;
    assign gain_in[1] = bus.gain2;
    assign gain_in[2] = bus.gain3;
    assign gain_in[3] = bus.gain4;

    // lrclk_d resets high so an lrclk already high at reset release is not an edge.
    assign frame_start = lrclk & ~lrclk_d;

    // ------------------------------------------------------------------
    // Effective gain for the frame being latched
    // ------------------------------------------------------------------
`ifdef SPLITTER_RAMP_EN
    localparam logic [GAINBITS-1:0] STEP = GAINBITS'(RAMP_STEP);

    // Move cur toward tgt by at most STEP; lands exactly on tgt when close.
    function automatic logic [GAINBITS-1:0] ramp_toward(
        input logic [GAINBITS-1:0] cur,
        input logic [GAINBITS-1:0] tgt
    );
        logic [GAINBITS-1:0] diff;
        if (tgt >= cur) begin
            diff        = tgt - cur;
            ramp_toward = (diff > STEP) ? cur + STEP : tgt;
        end else begin
            diff        = cur - tgt;
            ramp_toward = (diff > STEP) ? cur - STEP : tgt;
        end
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
`ifdef SPLITTER_RAMP_EN
            eff_next[i] = ramp_toward(eff_gain[i], gain_in[i]);
`else
            eff_next[i] = gain_in[i];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Shared multiplier: signed sample times zero-extended gain, then an
    // arithmetic shift by GAINBITS (floor toward -inf). |gain| < 1, so the
    // shifted product always fits back into BITSIZE bits.
    // ------------------------------------------------------------------
    assign eff_sel = eff_gain[ch];
    assign mul_a   = PW'(sample_r);
    assign mul_b   = $signed(PW'(eff_sel));
    assign prod    = mul_a * mul_b;
    assign stage_d = BITSIZE'(prod >>> GAINBITS);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge bclk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        calc_en   = 1'b0;
        update_en = 1'b0;
        busy_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    latch_en = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                busy_c  = 1'b1;
                calc_en = 1'b1;
                if (ch == 2'd3) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy_c    = 1'b1;
                update_en = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge bclk) begin
        if (!reset) begin
            lrclk_d  <= 1'b1;
            sample_r <= '0;
            ch       <= 2'd0;
            valid_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                eff_gain[i] <= '0;
                stage[i]    <= '0;
                out_r[i]    <= '0;
            end
        end else begin
            lrclk_d <= lrclk;
            valid_r <= update_en;

            if (latch_en) begin
                sample_r <= bus.in;
                ch       <= 2'd0;
                for (int i = 0; i < 4; i++) begin
                    eff_gain[i] <= eff_next[i];
                end
            end

            // ch wraps 3 -> 0 on the last channel, ready for the next frame.
            if (calc_en) begin
                stage[ch] <= stage_d;
                ch        <= ch + 2'd1;
            end

            if (update_en) begin
                for (int i = 0; i < 4; i++) begin
                    out_r[i] <= stage[i];
                end
            end
        end
    end

    assign bus.out1  = out_r[0];
    assign bus.out2  = out_r[1];
    assign bus.out3  = out_r[2];
    assign bus.out4  = out_r[3];
    assign bus.valid = valid_r;
    assign bus.busy  = busy_c;

endmodule
